rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, register data width.
REQ-002 Parameter ADDR_W, default 3, register address width (8 registers).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0  input  1  requester 0 (ALU writeback) write request.
REQ-006 addr0  input  ADDR_W  requester 0 destination register.
REQ-007 data0  input  DATA_W  requester 0 write data.
REQ-008 gnt0  output  1  requester 0 grant, one cycle per accepted write.
REQ-009 req1, addr1, data1, gnt1  same as REQ-005..008 for requester 1 (load unit).
REQ-010 stall  input  1  pipeline stall; blocks all new grants while high.
REQ-011 we  output  1  register-file write enable, registered.
REQ-012 waddr  output  ADDR_W  register-file write address, registered.
REQ-013 wdata  output  DATA_W  register-file write data, registered.
REQ-014 wr_count  output  8  count of issued writes since reset, wraps 255->0.

Function
REQ-015 Handshake: requester SHALL hold req/addr/data stable until it samples gnt high; transfer occurs in the cycle where req && gnt.
REQ-016 gnt0/gnt1 SHALL be combinational from req, stall and priority pointer; at most one grant high per cycle.
REQ-017 No grant SHALL be issued when stall=1 or rst=1.
REQ-018 Single request (other idle, stall=0) SHALL be granted the same cycle regardless of pointer.
REQ-019 Both requesting: grant goes to requester indicated by pointer prio (0 or 1).
REQ-020 After any grant, prio SHALL update to the non-granted requester; unchanged in cycles without a grant.
REQ-021 Latency: accepted write in cycle N SHALL appear as we=1 with the granted addr/data in cycle N+1, exactly one cycle.
REQ-022 we SHALL be 0 in every cycle following a no-grant cycle; waddr/wdata hold their last values when we=0.
REQ-023 Back-to-back grants SHALL produce we=1 in consecutive cycles (full throughput, one write/cycle).
REQ-024 Same-address simultaneous requests: both written in grant order; the later-granted data SHALL be final register content.
REQ-025 wr_count SHALL increment by 1 on each cycle with we=1, modulo 256.
REQ-026 Stall asserted mid-contention SHALL freeze prio; losing requester keeps req high and is served after stall drops.

Reset
REQ-027 On rising edge with rst=1: we=0, waddr=0, wdata=0, wr_count=0, prio=0 (requester 0 preferred).
REQ-028 Reset mid-operation SHALL suppress any write pending for cycle N+1 (we=0 the cycle after reset sampled); grant in the reset cycle is invalid and gnt=0.
REQ-029 First grant possible in the first cycle with rst=0.

Structure
REQ-030 Shared package rf_arb_pkg SHALL hold DATA_W/ADDR_W defaults and requester-index constants REQ_ALU=0, REQ_LD=1.
REQ-031 One sub-module rr_arb2 SHALL implement the 2-way round-robin pick and prio flop; rf_write_arbiter holds the output register stage and wr_count.
REQ-032 Output stage SHALL be plain flops with write enable, no latches; no combinational path from req to we/waddr/wdata.

Verification
REQ-033 rst=1 for 2 cycles then release, no requests -> we=0, waddr=0, wdata=0, wr_count=0, gnt0=gnt1=0.
REQ-034 req0=1, addr0=3, data0=0xA5 one cycle -> gnt0=1 same cycle; next cycle we=1, waddr=3, wdata=0xA5; wr_count=1.
REQ-035 req0 and req1 both high 4 cycles (addr0=1/data0=0x11, addr1=2/data1=0x22, fresh data each grant) -> grants alternate 0,1,0,1; we=1 four consecutive cycles.
REQ-036 Both request addr=5, data0=0x0F, data1=0xF0, prio=0 -> writes 0x0F then 0xF0 to reg 5 in consecutive cycles.
REQ-037 Contention with stall=1 for 3 cycles -> no grants, we=0, prio unchanged; stall drop -> prio-indicated requester granted first.
REQ-038 Grant in cycle N with rst=1 asserted in cycle N -> we=0 in N+1; 256 writes after reset -> wr_count=0.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared constants for the register-file write arbiter: default widths and
// requester indices used to address the grant vector.
package rf_arb_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int REQ_ALU    = 0;
  localparam int REQ_LD     = 1;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Requester/stall/register-file bundle between the writeback sources and the arbiter.
interface rf_write_arbiter_if
  import rf_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              req0, gnt0, req1, gnt1, stall, we;
  logic [ADDR_W-1:0] addr0, addr1, waddr;
  logic [DATA_W-1:0] data0, data1, wdata;
  logic [7:0]        wr_count;

  modport master (
    output req0, addr0, data0, req1, addr1, data1, stall,
    input  gnt0, gnt1, we, waddr, wdata, wr_count
  );
  modport slave (
    input  req0, addr0, data0, req1, addr1, data1, stall,
    output gnt0, gnt1, we, waddr, wdata, wr_count
  );
endinterface

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-way round-robin pick. Grants are combinational; the pointer flips to the
// loser after every grant and holds otherwise (including while stalled).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       stall,
  output logic [1:0] gnt
);
  logic prio;

  always_comb begin
    gnt = '0;
    if (!stall && !rst) begin
      if (&req) gnt[prio] = 1'b1;
      else      gnt = req;
    end
  end

  // gnt[0] set means requester 0 won, so requester 1 is preferred next.
  always_ff @(posedge clk) begin
    if (rst)       prio <= 1'b0;
    else if (|gnt) prio <= gnt[0];
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: round-robin between ALU writeback and load unit,
// one registered write per cycle, plus a wrapping count of issued writes.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic               clk,
  input logic               rst,
  rf_write_arbiter_if.slave bus
);
  logic [1:0]        gnt;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        cnt_q;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   ({bus.req1, bus.req0}),
    .stall (bus.stall),
    .gnt   (gnt)
  );

  // Count advances with the grant so it is already updated when we rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      we_q <= |gnt;
      if (|gnt) begin
        waddr_q <= gnt[REQ_LD] ? bus.addr1 : bus.addr0;
        wdata_q <= gnt[REQ_LD] ? bus.data1 : bus.data0;
        cnt_q   <= cnt_q + 8'd1;
      end
    end
  end

  assign bus.gnt0     = gnt[REQ_ALU];
  assign bus.gnt1     = gnt[REQ_LD];
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign bus.wr_count = cnt_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized bench for rf_write_arbiter against a transaction-level model of
// the arbitration rules, with directed scenarios for the corner cases.
module tb_rf_write_arbiter;
  import rf_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.DATA_W(DEF_DATA_W), .ADDR_W(DEF_ADDR_W)) bus ();

  rf_write_arbiter #(.DATA_W(DEF_DATA_W), .ADDR_W(DEF_ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // requester intent (held until granted)
  logic       r0, r1, st;
  logic [2:0] a0, a1;
  logic [7:0] d0, d1;

  // reference model state
  int         m_prio;
  logic       m_we;
  logic [2:0] m_waddr;
  logic [7:0] m_wdata;
  int         m_cnt;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // One clock: drive, check grants mid-cycle, advance model, check outputs.
  task automatic step();
    logic en, e0, e1;
    bus.req0 = r0; bus.addr0 = a0; bus.data0 = d0;
    bus.req1 = r1; bus.addr1 = a1; bus.data1 = d1;
    bus.stall = st;
    @(negedge clk);
    en = !rst && !st;
    e0 = en && r0 && (!r1 || m_prio == 0);
    e1 = en && r1 && (!r0 || m_prio == 1);
    chk("gnt0", bus.gnt0, e0);
    chk("gnt1", bus.gnt1, e1);
    @(posedge clk);
    if (rst) begin
      m_we = 0; m_waddr = 0; m_wdata = 0; m_cnt = 0; m_prio = 0;
    end else begin
      m_we = e0 || e1;
      if (e0) begin m_waddr = a0; m_wdata = d0; end
      if (e1) begin m_waddr = a1; m_wdata = d1; end
      if (m_we) begin
        m_cnt  = (m_cnt + 1) % 256;
        m_prio = e0 ? 1 : 0;
      end
    end
    if (e0) r0 = 0;
    if (e1) r1 = 0;
    #1;
    chk("we",       bus.we,       m_we);
    chk("waddr",    bus.waddr,    m_waddr);
    chk("wdata",    bus.wdata,    m_wdata);
    chk("wr_count", bus.wr_count, m_cnt[7:0]);
  endtask

  task automatic idle(int n);
    r0 = 0; r1 = 0; st = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(int n);
    rst = 1;
    for (int i = 0; i < n; i++) step();
    rst = 0;
  endtask

  initial begin
    r0 = 0; r1 = 0; st = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    m_prio = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_cnt = 0;

    // reset for two cycles, then idle
    do_reset(2);
    idle(1);
    chk("rst_we",  bus.we,       0);
    chk("rst_cnt", bus.wr_count, 0);

    // single ALU write
    r0 = 1; a0 = 3; d0 = 8'hA5;
    step();
    chk("single_waddr", bus.waddr,    3);
    chk("single_wdata", bus.wdata,    8'hA5);
    chk("single_cnt",   bus.wr_count, 1);
    idle(1);

    // sustained contention from prio=0: alternate 0,1,0,1
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      if (!r0) begin r0 = 1; a0 = 1; d0 = 8'h11 + 8'(i); end
      if (!r1) begin r1 = 1; a1 = 2; d1 = 8'h22 + 8'(i); end
      step();
      chk("alt_we",    bus.we,    1);
      chk("alt_waddr", bus.waddr, (i % 2 == 0) ? 1 : 2);
    end
    idle(2);

    // same destination: later-granted data is last
    do_reset(1);
    r0 = 1; a0 = 5; d0 = 8'h0F;
    r1 = 1; a1 = 5; d1 = 8'hF0;
    step();
    chk("same_first",  bus.wdata, 8'h0F);
    step();
    chk("same_second", bus.wdata, 8'hF0);
    idle(1);

    // stall during contention freezes pointer (prio=1 after last grant to 1? no: to 0)
    r0 = 1; a0 = 6; d0 = 8'h66;
    r1 = 1; a1 = 7; d1 = 8'h77;
    st = 1;
    for (int i = 0; i < 3; i++) step();
    chk("stall_we", bus.we, 0);
    st = 0;
    step();
    chk("stall_drop_waddr", bus.waddr, 6);
    step();
    chk("stall_loser_waddr", bus.waddr, 7);
    idle(1);

    // grant coincident with reset is squashed
    r0 = 1; a0 = 2; d0 = 8'h5A;
    rst = 1;
    step();
    rst = 0;
    chk("rst_grant_we", bus.we, 0);
    step();
    chk("post_rst_we", bus.we, 1);

    // 256 writes from reset wraps the counter
    do_reset(1);
    for (int i = 0; i < 256; i++) begin
      r0 = 1; a0 = 3'(i); d0 = 8'(i);
      step();
    end
    chk("wrap_cnt", bus.wr_count, 0);
    idle(1);

    // randomized traffic with occasional stall and reset
    for (int i = 0; i < 1500; i++) begin
      if (!r0 && ($urandom_range(0, 2) != 0)) begin
        r0 = 1; a0 = 3'($urandom); d0 = 8'($urandom);
      end
      if (!r1 && ($urandom_range(0, 2) != 0)) begin
        r1 = 1; a1 = 3'($urandom); d1 = 8'($urandom);
      end
      st  = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 60) == 0);
      step();
    end
    rst = 0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
